// File: rtl/he_scale_encoder_if.sv
// Request/response bundle for he_scale_encoder (parameter W = operand width).
// Handshake: a request transfers on a posedge where valid_i && ready_o; each result is a one-cycle done_o pulse.
interface he_scale_encoder_if #(parameter int W = 32);
    logic [W-1:0] t;
    logic [W-1:0] q;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_o;
    logic         done_o;
    logic         err_o;

    modport master (output t, q, data_i, valid_i, input ready_o, data_o, done_o, err_o);
    modport slave  (input t, q, data_i, valid_i, output ready_o, data_o, done_o, err_o);
endinterface

// File: rtl/he_scale_encoder.sv
// Iterative scaler: data_o = floor(data_i * q / t) mod q (shift-add multiply, two restoring divides).
// Define HE_ENC_ROUND_EN to add floor(t/2) before the first divide (round-to-nearest).
module he_scale_encoder #(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    he_scale_encoder_if.slave bus,
    output logic [2:0]        dbg_state_o
);
    localparam int CW = $clog2(2 * W);
    localparam logic [CW-1:0] MUL_LAST = CW'(W - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(2 * W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_MOD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   msg_q, msg_d;
    logic [W-1:0]   tmod_q, tmod_d;
    logic [W-1:0]   qmod_q, qmod_d;
    logic [2*W-1:0] mc_q, mc_d;
    logic [2*W-1:0] p_q, p_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   data_q, data_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [2*W-1:0] mul_acc;
    logic [2*W-1:0] div_init;
    logic [W-1:0]   rem_init;
    logic [W-1:0]   divisor;
    logic [W:0]     trial;
    logic [W-1:0]   diff;
    logic           q_bit;
    logic [W-1:0]   step_rem;
    logic [2*W-1:0] step_p;

    assign mul_acc = msg_q[0] ? (p_q + mc_q) : p_q;

`ifdef HE_ENC_ROUND_EN
    // One extra bit carries the rounding sum; it seeds the remainder of the first divide.
    logic [2*W:0] rounded;
    assign rounded  = {1'b0, mul_acc} + {{(W + 2){1'b0}}, tmod_q[W-1:1]};
    assign div_init = rounded[2*W-1:0];
    assign rem_init = {{(W - 1){1'b0}}, rounded[2*W]};
`else
    assign div_init = mul_acc;
    assign rem_init = '0;
`endif

    // Shared restoring-division step: p_q shifts out the dividend MSB and takes in the quotient bit.
    assign divisor  = (state_q == S_MOD) ? qmod_q : tmod_q;
    assign trial    = {rem_q, p_q[2*W-1]};
    assign q_bit    = (trial >= {1'b0, divisor});
    assign diff     = trial[W-1:0] - divisor;
    assign step_rem = q_bit ? diff : trial[W-1:0];
    assign step_p   = {p_q[2*W-2:0], q_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        tmod_d  = tmod_q;
        qmod_d  = qmod_q;
        mc_d    = mc_q;
        p_d     = p_q;
        rem_d   = rem_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.valid_i) begin
                    msg_d   = bus.data_i;
                    tmod_d  = bus.t;
                    qmod_d  = bus.q;
                    mc_d    = {{W{1'b0}}, bus.q};
                    p_d     = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (tmod_q == '0 || qmod_q == '0) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    p_d   = mul_acc;
                    msg_d = msg_q >> 1;
                    mc_d  = mc_q << 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == MUL_LAST) begin
                        p_d     = div_init;
                        rem_d   = rem_init;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                p_d   = step_p;
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DIV_LAST) begin
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MOD;
                end
            end
            S_MOD: begin
                p_d   = step_p;
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DIV_LAST) begin
                    data_d  = step_rem;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            msg_q   <= '0;
            tmod_q  <= '0;
            qmod_q  <= '0;
            mc_q    <= '0;
            p_q     <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            tmod_q  <= tmod_d;
            qmod_q  <= qmod_d;
            mc_q    <= mc_d;
            p_q     <= p_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready_o  = (state_q == S_IDLE);
    assign bus.data_o   = data_q;
    assign bus.done_o   = done_q;
    assign bus.err_o    = err_q;
    assign dbg_state_o  = 3'(state_q);
endmodule

// File: tb/tb_he_scale_encoder.sv
// Directed bench for he_scale_encoder: vector table plus reset-abort and back-to-back sequences.
// Latency is counted with the accepting cycle as cycle 1 (161 cycles normal, 2 on the error path).
module tb_he_scale_encoder;
    localparam int W = 32;
`ifdef HE_ENC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] dbg_state;

    he_scale_encoder_if #(.W(W)) bus ();
    he_scale_encoder #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] t;
        logic [W-1:0] q;
        logic [W-1:0] d;
        logic [W-1:0] exp_trunc;
        logic [W-1:0] exp_round;
        logic         exp_err;
        int           exp_cyc;
    } vec_t;

    vec_t         vecs[10];
    int           n_checks   = 0;
    int           n_pass     = 0;
    int           done_count = 0;
    logic [W-1:0] exp_q[$];

    always @(negedge clk) if (bus.done_o) done_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issues one request from a negedge and waits (bounded) for its done_o pulse.
    task automatic run_req(input logic [W-1:0] t, input logic [W-1:0] q, input logic [W-1:0] d,
                           output logic [W-1:0] res, output logic err, output int cyc,
                           output bit seen);
        int k;
        k = 0;
        while (!bus.ready_o && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_req", W'(bus.ready_o), W'(1));
        bus.t = t; bus.q = q; bus.data_i = d; bus.valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.t = $urandom; bus.q = $urandom; bus.data_i = $urandom;
        check("ready_low_busy", W'(bus.ready_o), W'(0));
        check("accept_clears_err", W'(bus.err_o), W'(0));
        seen = 1'b0; cyc = 0; res = '0; err = 1'b0;
        for (int e = 1; e <= 400 && !seen; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done_o) begin
                seen = 1'b1;
                cyc  = e + 1;
                res  = bus.data_o;
                err  = bus.err_o;
            end
        end
    endtask

    initial begin
        logic [W-1:0] res;
        logic         err;
        int           cyc;
        bit           seen;
        int           c0;
        int           busy_bad;

        vecs[0] = '{32'd16, 32'd1024, 32'd3,  32'd192, 32'd192, 1'b0, 161};
        vecs[1] = '{32'd16, 32'd1024, 32'd20, 32'd256, 32'd256, 1'b0, 161};
        vecs[2] = '{32'd3,  32'd100,  32'd2,  32'd66,  32'd67,  1'b0, 161};
        vecs[3] = '{32'd0,  32'd97,   32'd5,  32'd0,   32'd0,   1'b1, 2};
        vecs[4] = '{32'd1,  32'd7,    32'd5,  32'd0,   32'd0,   1'b0, 161};
        vecs[5] = '{32'd5,  32'd13,   32'd4,  32'd10,  32'd10,  1'b0, 161};
        vecs[6] = '{32'd7,  32'd1000, 32'd10, 32'd428, 32'd429, 1'b0, 161};
        vecs[7] = '{32'd5,  32'd0,    32'd3,  32'd0,   32'd0,   1'b1, 2};
        vecs[8] = '{32'd1,  32'd1000, 32'd0,  32'd0,   32'd0,   1'b0, 161};
        vecs[9] = '{32'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 161};

        bus.t = '0; bus.q = '0; bus.data_i = '0; bus.valid_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", W'(bus.ready_o), W'(1));
        check("rst_done",  W'(bus.done_o),  W'(0));
        check("rst_err",   W'(bus.err_o),   W'(0));
        check("rst_data",  bus.data_o,      W'(0));
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].t, vecs[i].q, vecs[i].d, res, err, cyc, seen);
            check($sformatf("v%0d_done_seen", i), W'(seen), W'(1));
            check($sformatf("v%0d_data", i), res, ROUND ? vecs[i].exp_round : vecs[i].exp_trunc);
            check($sformatf("v%0d_err", i), W'(err), W'(vecs[i].exp_err));
            check($sformatf("v%0d_latency", i), W'(cyc), W'(vecs[i].exp_cyc));
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), W'(bus.done_o), W'(0));
            check($sformatf("v%0d_ready_after", i), W'(bus.ready_o), W'(1));
        end

        // Reset during DIV aborts the request.
        bus.t = 32'd16; bus.q = 32'd1024; bus.data_i = 32'd3; bus.valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_in_div", W'(dbg_state), W'(2));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", W'(bus.ready_o), W'(1));
        check("abort_done",  W'(bus.done_o),  W'(0));
        check("abort_data",  bus.data_o,      W'(0));
        rst = 1'b1;
        c0 = done_count;
        repeat (200) @(negedge clk);
        #1;
        check("abort_no_done", W'(done_count - c0), W'(0));

        // Back-to-back with valid_i held high.
        @(negedge clk);
        c0 = done_count;
        exp_q.push_back(32'd1024);
        exp_q.push_back(32'd2048);
        bus.t = 32'd4; bus.q = 32'd4096; bus.data_i = 32'd1; bus.valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_i = 32'd2;
        check("b2b_busy", W'(bus.ready_o), W'(0));
        busy_bad = 0;
        for (int r = 0; r < 2; r++) begin
            seen = 1'b0;
            for (int e = 0; e < 400 && !seen; e++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.done_o) begin
                    seen = 1'b1;
                    check($sformatf("b2b_data%0d", r), bus.data_o, exp_q.pop_front());
                    check($sformatf("b2b_ready_in_done%0d", r), W'(bus.ready_o), W'(0));
                end else if (bus.ready_o) begin
                    busy_bad++;
                end
            end
            check($sformatf("b2b_done_seen%0d", r), W'(seen), W'(1));
            if (r == 0) begin
                @(posedge clk);
                @(negedge clk);
                check("b2b_ready_after_done", W'(bus.ready_o), W'(1));
                @(posedge clk);
                @(negedge clk);
                check("b2b_reaccepted", W'(bus.ready_o), W'(0));
                bus.valid_i = 1'b0;
            end
        end
        check("b2b_ready_low_busy", W'(busy_bad), W'(0));
        repeat (200) @(negedge clk);
        #1;
        check("b2b_pulse_count", W'(done_count - c0), W'(2));
        check("b2b_queue_empty", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
